// File: rtl/dpr_bist_pkg.sv
// Shared types and helpers for the dual-port RAM march BIST.
package dpr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0   = 3'd2,
    ST_D0   = 3'd3,
    ST_W1   = 3'd4,
    ST_R1   = 3'd5,
    ST_D1   = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  localparam logic PH_R0 = 1'b0;
  localparam logic PH_R1 = 1'b1;

  // Pattern is computed at a fixed working width; callers truncate to DATA_SIZE.
  localparam int PAT_W = 32;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/dpr_bist_checker.sv
// One-cycle read-compare pipeline with saturating error count and first-fail capture.
module dpr_bist_checker
  import dpr_bist_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   rd_issue,
  input  logic [DATA_SIZE-1:0]   exp_data,
  input  logic [ADDR_SIZE-1:0]   addr,
  input  logic                   phase,
  input  logic [DATA_SIZE-1:0]   rd_data,
  output logic [ADDR_SIZE+1:0]   err_count,
  output logic                   fail_valid,
  output logic [ADDR_SIZE-1:0]   fail_addr,
  output logic [DATA_SIZE-1:0]   fail_data,
  output logic                   fail_phase
);

  localparam logic [ADDR_SIZE+1:0] ERR_ONE = (ADDR_SIZE+2)'(1);

  logic                 exp_valid_q;
  logic [DATA_SIZE-1:0] exp_data_q;
  logic [ADDR_SIZE-1:0] exp_addr_q;
  logic                 exp_phase_q;
  logic [ADDR_SIZE+1:0] err_q, err_d;
  logic                 fv_q, fv_d;
  logic [ADDR_SIZE-1:0] fa_q, fa_d;
  logic [DATA_SIZE-1:0] fd_q, fd_d;
  logic                 fp_q, fp_d;
  logic                 mismatch_s;

  // Compare the returning word and work out the next result state.
  always_comb begin
    mismatch_s = 1'b0;
    err_d      = err_q;
    fv_d       = fv_q;
    fa_d       = fa_q;
    fd_d       = fd_q;
    fp_d       = fp_q;
    if (exp_valid_q && (rd_data != exp_data_q)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (err_q != '1)) begin
      err_d = err_q + ERR_ONE;
    end else begin
      err_d = err_q;
    end
    if (mismatch_s && !fv_q) begin
      fv_d = 1'b1;
      fa_d = exp_addr_q;
      fd_d = rd_data;
      fp_d = exp_phase_q;
    end else begin
      fv_d = fv_q;
    end
  end

  // Expectation pipeline and result registers; clear also flushes the pipeline.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      exp_phase_q <= PH_R0;
      err_q       <= '0;
      fv_q        <= 1'b0;
      fa_q        <= '0;
      fd_q        <= '0;
      fp_q        <= 1'b0;
    end else begin
      exp_valid_q <= rd_issue;
      if (rd_issue) begin
        exp_data_q  <= exp_data;
        exp_addr_q  <= addr;
        exp_phase_q <= phase;
      end
      err_q <= err_d;
      fv_q  <= fv_d;
      fa_q  <= fa_d;
      fd_q  <= fd_d;
      fp_q  <= fp_d;
    end
  end

  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_addr  = fa_q;
  assign fail_data  = fd_q;
  assign fail_phase = fp_q;

endmodule

// File: rtl/dpr_bist.sv
// March BIST initiator for a true dual-port RAM: W0(A) R0(B) W1(B, complement) R1(A).
module dpr_bist
  import dpr_bist_pkg::*;
#(
  parameter int                   ADDR_SIZE = 8,
  parameter int                   DATA_SIZE = 8,
  parameter int                   RAM_SIZE  = 1 << ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0] SEED      = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE+1:0] err_count,
  output logic                 fail_valid,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [DATA_SIZE-1:0] fail_data,
  output logic                 fail_phase,
  output logic                 en_a,
  output logic                 we_a,
  output logic [ADDR_SIZE-1:0] addr_a,
  output logic [DATA_SIZE-1:0] din_a,
  input  logic [DATA_SIZE-1:0] dout_a,
  output logic                 en_b,
  output logic                 we_b,
  output logic [ADDR_SIZE-1:0] addr_b,
  output logic [DATA_SIZE-1:0] din_b,
  input  logic [DATA_SIZE-1:0] dout_b
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(RAM_SIZE - 1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 accept_s;
  logic [DATA_SIZE-1:0] pat_s;

  logic                 en_a_q, en_a_d, we_a_q, we_a_d;
  logic                 en_b_q, en_b_d, we_b_q, we_b_d;
  logic [ADDR_SIZE-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_SIZE-1:0] din_a_q, din_a_d, din_b_q, din_b_d;
  logic                 rd_issue_q, rd_issue_d;
  logic [DATA_SIZE-1:0] rd_exp_q, rd_exp_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_phase_q, rd_phase_d;
  logic                 sel_a_q;
  logic                 busy_q, done_q;

  assign pat_s = DATA_SIZE'(pattern(PAT_W'(addr_q), PAT_W'(SEED)));

  // Phase sequencing and address counter; phases exit on terminal count.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_W0;
          addr_d   = '0;
          accept_s = 1'b1;
        end else begin
          state_d  = state_q;
        end
      end
      ST_W0, ST_R0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = (state_q == ST_W0) ? ST_R0 : ST_D0;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
        end
      end
      ST_D0: begin
        state_d = ST_W1;
        addr_d  = ADDR_LAST;
      end
      ST_W1, ST_R1: begin
        if (addr_q == '0) begin
          state_d = (state_q == ST_W1) ? ST_R1 : ST_D1;
          addr_d  = (state_q == ST_W1) ? ADDR_LAST : '0;
        end else begin
          addr_d  = addr_q - ADDR_ONE;
        end
      end
      ST_D1: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // RAM port drive and read expectation for the next registered cycle.
  always_comb begin
    en_a_d     = 1'b0;
    we_a_d     = 1'b0;
    addr_a_d   = '0;
    din_a_d    = '0;
    en_b_d     = 1'b0;
    we_b_d     = 1'b0;
    addr_b_d   = '0;
    din_b_d    = '0;
    rd_issue_d = 1'b0;
    rd_exp_d   = '0;
    rd_addr_d  = '0;
    rd_phase_d = PH_R0;
    case (state_q)
      ST_W0: begin
        en_a_d   = 1'b1;
        we_a_d   = 1'b1;
        addr_a_d = addr_q;
        din_a_d  = pat_s;
      end
      ST_R0: begin
        en_b_d     = 1'b1;
        addr_b_d   = addr_q;
        rd_issue_d = 1'b1;
        rd_exp_d   = pat_s;
        rd_addr_d  = addr_q;
        rd_phase_d = PH_R0;
      end
      ST_W1: begin
        en_b_d   = 1'b1;
        we_b_d   = 1'b1;
        addr_b_d = addr_q;
        din_b_d  = ~pat_s;
      end
      ST_R1: begin
        en_a_d     = 1'b1;
        addr_a_d   = addr_q;
        rd_issue_d = 1'b1;
        rd_exp_d   = ~pat_s;
        rd_addr_d  = addr_q;
        rd_phase_d = PH_R1;
      end
      default: begin
        en_a_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      en_a_q     <= 1'b0;
      we_a_q     <= 1'b0;
      addr_a_q   <= '0;
      din_a_q    <= '0;
      en_b_q     <= 1'b0;
      we_b_q     <= 1'b0;
      addr_b_q   <= '0;
      din_b_q    <= '0;
      rd_issue_q <= 1'b0;
      rd_exp_q   <= '0;
      rd_addr_q  <= '0;
      rd_phase_q <= PH_R0;
      sel_a_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      en_a_q     <= en_a_d;
      we_a_q     <= we_a_d;
      addr_a_q   <= addr_a_d;
      din_a_q    <= din_a_d;
      en_b_q     <= en_b_d;
      we_b_q     <= we_b_d;
      addr_b_q   <= addr_b_d;
      din_b_q    <= din_b_d;
      rd_issue_q <= rd_issue_d;
      rd_exp_q   <= rd_exp_d;
      rd_addr_q  <= rd_addr_d;
      rd_phase_q <= rd_phase_d;
      // Tracks which port's data returns in the checker's compare cycle.
      sel_a_q    <= (rd_phase_q == PH_R1);
      busy_q     <= (state_q != ST_IDLE) && (state_q != ST_DONE);
      done_q     <= (state_q == ST_DONE) && !accept_s;
    end
  end

  dpr_bist_checker #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept_s),
    .rd_issue   (rd_issue_q),
    .exp_data   (rd_exp_q),
    .addr       (rd_addr_q),
    .phase      (rd_phase_q),
    .rd_data    (sel_a_q ? dout_a : dout_b),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_phase (fail_phase)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = done_q && (err_count == '0);
  assign en_a   = en_a_q;
  assign we_a   = we_a_q;
  assign addr_a = addr_a_q;
  assign din_a  = din_a_q;
  assign en_b   = en_b_q;
  assign we_b   = we_b_q;
  assign addr_b = addr_b_q;
  assign din_b  = din_b_q;

endmodule

// File: tb/tb_dpr_bist.sv
// Scoreboard bench: two BIST instances (SEED 0 and 0xA5) on behavioural RAMs with injectable stuck bits.
module tb_dpr_bist;

  localparam int N = 256;
  localparam int LAT = 4 * N + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-instance signals (0: SEED=0, 1: SEED=0xA5)
  logic       rst0 = 1'b1, start0 = 1'b0, rst1 = 1'b1, start1 = 1'b0;
  logic       busy0, done0, pass0, fv0, fp0, busy1, done1, pass1, fv1, fp1;
  logic [9:0] err0, err1;
  logic [7:0] fad0, fdat0, fad1, fdat1;
  logic       en_a0, we_a0, en_b0, we_b0, en_a1, we_a1, en_b1, we_b1;
  logic [7:0] addr_a0, din_a0, addr_b0, din_b0, addr_a1, din_a1, addr_b1, din_b1;
  logic [7:0] dout_a0 = 8'h0, dout_b0 = 8'h0, dout_a1 = 8'h0, dout_b1 = 8'h0;

  dpr_bist #(.ADDR_SIZE(8), .DATA_SIZE(8), .RAM_SIZE(N), .SEED(8'h00)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_addr(fad0), .fail_data(fdat0), .fail_phase(fp0),
    .en_a(en_a0), .we_a(we_a0), .addr_a(addr_a0), .din_a(din_a0), .dout_a(dout_a0),
    .en_b(en_b0), .we_b(we_b0), .addr_b(addr_b0), .din_b(din_b0), .dout_b(dout_b0));

  dpr_bist #(.ADDR_SIZE(8), .DATA_SIZE(8), .RAM_SIZE(N), .SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_addr(fad1), .fail_data(fdat1), .fail_phase(fp1),
    .en_a(en_a1), .we_a(we_a1), .addr_a(addr_a1), .din_a(din_a1), .dout_a(dout_a1),
    .en_b(en_b1), .we_b(we_b1), .addr_b(addr_b1), .din_b(din_b1), .dout_b(dout_b1));

  // Behavioural RAMs with read-side stuck-at faults at up to two addresses.
  logic [7:0] mem0 [N];
  logic [7:0] mem1 [N];
  logic       flt_on0 = 1'b0, flt_on1 = 1'b0;
  logic [7:0] flt_x0 = 8'h0, flt_y0 = 8'h0, flt_s0_0 = 8'h0, flt_s1_0 = 8'h0;
  logic [7:0] flt_x1 = 8'h0, flt_y1 = 8'h0, flt_s0_1 = 8'h0, flt_s1_1 = 8'h0;

  function automatic logic [7:0] corrupt(input logic on, input logic [7:0] a, input logic [7:0] d,
                                         input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] s0, input logic [7:0] s1);
    if (on && (a == x || a == y)) return (d & ~s0) | s1;
    return d;
  endfunction

  always @(posedge clk) begin
    if (en_a0) begin
      if (we_a0) mem0[addr_a0] <= din_a0;
      else dout_a0 <= corrupt(flt_on0, addr_a0, mem0[addr_a0], flt_x0, flt_y0, flt_s0_0, flt_s1_0);
    end
    if (en_b0) begin
      if (we_b0) mem0[addr_b0] <= din_b0;
      else dout_b0 <= corrupt(flt_on0, addr_b0, mem0[addr_b0], flt_x0, flt_y0, flt_s0_0, flt_s1_0);
    end
    if (en_a1) begin
      if (we_a1) mem1[addr_a1] <= din_a1;
      else dout_a1 <= corrupt(flt_on1, addr_a1, mem1[addr_a1], flt_x1, flt_y1, flt_s0_1, flt_s1_1);
    end
    if (en_b1) begin
      if (we_b1) mem1[addr_b1] <= din_b1;
      else dout_b1 <= corrupt(flt_on1, addr_b1, mem1[addr_b1], flt_x1, flt_y1, flt_s0_1, flt_s1_1);
    end
  end

  // Scoreboard
  typedef struct {
    int         lat;
    logic [9:0] err;
    logic       fv;
    logic [7:0] fa;
    logic [7:0] fd;
    logic       fp;
    logic       pass;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   start_cyc0 = 0, start_cyc1 = 0;
  int   done_cnt0 = 0, done_cnt1 = 0;
  logic done0_p = 1'b0, done1_p = 1'b0;

  task automatic compare_result(input string tag, input exp_t e, input int lat, input logic [9:0] err,
                                input logic fv, input logic [7:0] fa, input logic [7:0] fd,
                                input logic fp, input logic pass, input logic busy);
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_err_count"}, 64'(err), 64'(e.err));
    check({tag, "_fail_valid"}, 64'(fv), 64'(e.fv));
    check({tag, "_fail_addr"}, 64'(fa), 64'(e.fa));
    check({tag, "_fail_data"}, 64'(fd), 64'(e.fd));
    check({tag, "_fail_phase"}, 64'(fp), 64'(e.fp));
    check({tag, "_pass"}, 64'(pass), 64'(e.pass));
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
  endtask

  // Monitor: compare results whenever done rises.
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !done0_p) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done0: got done with empty queue (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        compare_result("run0", e, cyc - start_cyc0, err0, fv0, fad0, fdat0, fp0, pass0, busy0);
      end
      done_cnt0 <= done_cnt0 + 1;
    end
    if (done1 && !done1_p) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1: got done with empty queue (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        compare_result("run1", e, cyc - start_cyc1, err1, fv1, fad1, fdat1, fp1, pass1, busy1);
      end
      done_cnt1 <= done_cnt1 + 1;
    end
    done0_p <= done0;
    done1_p <= done1;
  end

  // Port-trace monitor for instance 0: expected drive derived from cycles since busy rose.
  logic busy0_p = 1'b0;
  int   rise0 = 0;
  always @(negedge clk) begin
    int         t;
    int         a;
    logic [7:0] av;
    logic [35:0] ev;
    ev = '0;
    if (busy0) begin
      t = busy0_p ? (cyc - rise0) : 0;
      if (t < 256) begin
        av = 8'(t);
        ev = {1'b1, 1'b1, av, av, 1'b0, 1'b0, 8'h00, 8'h00};
      end else if (t < 512) begin
        av = 8'(t - 256);
        ev = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, av, 8'h00};
      end else if (t >= 513 && t < 769) begin
        a  = 255 - (t - 513);
        av = 8'(a);
        ev = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, av, ~av};
      end else if (t >= 769 && t < 1025) begin
        a  = 255 - (t - 769);
        av = 8'(a);
        ev = {1'b1, 1'b0, av, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
      end
    end
    check("port_trace", 64'({en_a0, we_a0, addr_a0, din_a0, en_b0, we_b0, addr_b0, din_b0}), 64'(ev));
    if (busy0 && !busy0_p) rise0 <= cyc;
    busy0_p <= busy0;
  end

  task automatic pulse(input int inst);
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (inst == 0) begin start0 = 1'b0; start_cyc0 = cyc; end
    else begin start1 = 1'b0; start_cyc1 = cyc; end
  endtask

  task automatic wait_done(input int inst);
    int base;
    int n;
    base = (inst == 0) ? done_cnt0 : done_cnt1;
    n = 0;
    while (((inst == 0) ? done_cnt0 : done_cnt1) == base && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 64'(n < LAT + 50), 64'(1));
  endtask

  function automatic exp_t mk(input logic [9:0] err, input logic fv, input logic [7:0] fa,
                              input logic [7:0] fd, input logic fp, input logic pass);
    exp_t e;
    e.lat = LAT; e.err = err; e.fv = fv; e.fa = fa; e.fd = fd; e.fp = fp; e.pass = pass;
    return e;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ports", 64'({en_a0, we_a0, addr_a0, din_a0, en_b0, we_b0, addr_b0, din_b0}), 64'(0));
    check("reset_status", 64'({busy0, done0, pass0, err0}), 64'(0));
    check("reset_fail", 64'({fv0, fad0, fdat0, fp0}), 64'(0));
    rst0 = 1'b0;

    // Fault-free run
    q0.push_back(mk(10'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    pulse(0);
    wait_done(0);

    // Stuck-at-1 bit0 at 0x05: only R1 sees it; restart from DONE
    flt_on0 = 1'b1; flt_x0 = 8'h05; flt_y0 = 8'h05; flt_s0_0 = 8'h00; flt_s1_0 = 8'h01;
    q0.push_back(mk(10'd1, 1'b1, 8'h05, 8'hFB, 1'b1, 1'b0));
    pulse(0);
    check("restart_done_cleared", 64'({done0, pass0}), 64'(0));
    wait_done(0);

    // Fault-free restart clears previous failure; a start pulse mid-run is ignored
    flt_on0 = 1'b0;
    q0.push_back(mk(10'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    pulse(0);
    check("restart_clears_err", 64'({err0, fv0, fad0, fdat0, fp0}), 64'(0));
    repeat (297) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);

    // R0 failure, then reset during W1
    flt_on0 = 1'b1; flt_x0 = 8'h03; flt_y0 = 8'h03; flt_s0_0 = 8'h00; flt_s1_0 = 8'h80;
    pulse(0);
    repeat (600) @(negedge clk);
    check("err_before_rst", 64'({err0, fv0, fad0, fp0}), 64'({10'd1, 1'b1, 8'h03, 1'b0}));
    check("busy_before_rst", 64'(busy0), 64'(1));
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_midtest_ram", 64'({en_a0, en_b0, we_a0, we_b0}), 64'(0));
    check("rst_midtest_status", 64'({busy0, done0, err0, fv0}), 64'(0));
    rst0 = 1'b0;
    flt_on0 = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_rst", 64'({busy0, done0}), 64'(0));
    q0.push_back(mk(10'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    pulse(0);
    wait_done(0);

    // SEED=0xA5, stuck-at-0 bit7 at 0x10 and 0x20: both fail in R0
    @(negedge clk);
    rst1 = 1'b0;
    flt_on1 = 1'b1; flt_x1 = 8'h10; flt_y1 = 8'h20; flt_s0_1 = 8'h80; flt_s1_1 = 8'h00;
    q1.push_back(mk(10'd2, 1'b1, 8'h10, 8'h35, 1'b0, 1'b0));
    pulse(1);
    wait_done(1);

    repeat (3) @(negedge clk);
    check("done_held", 64'({done0, done1}), 64'(2'b11));
    check("scoreboard0_empty", 64'(q0.size()), 64'(0));
    check("scoreboard1_empty", 64'(q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpr_bist.md
Name: dpr_bist

Overview:
- Built-in self-test initiator for the true dual-port RAM (True_DPR). It drives both RAM ports and checks the data that comes back.
- Runs a four-phase march: write via A, read via B, write the complement via B, read via A.
- Compares every read word against the expected pattern and reports pass/fail, the error count and the first failing location.
- Sits beside the RAM. Its RAM-side outputs connect 1:1 to the RAM's en/we/din/addr inputs, and the RAM's dout_a/dout_b feed back into it.

Parameters:
- ADDR_SIZE, 8, RAM address width.
- DATA_SIZE, 8, RAM word width.
- RAM_SIZE, 1 << ADDR_SIZE, number of words tested (N).
- SEED, 0, DATA_SIZE-bit XOR mask applied to the pattern.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test complete; held until the next start or rst.
- pass  out  1  done && err_count==0.
- err_count  out  ADDR_SIZE+2  mismatch count, saturating.
- fail_valid  out  1  first-failure capture is valid.
- fail_addr  out  ADDR_SIZE  address of the first mismatch.
- fail_data  out  DATA_SIZE  data actually read at the first mismatch.
- fail_phase  out  1  0 = failure in phase R0, 1 = failure in phase R1.
- en_a, we_a  out  1  RAM port A enable / write enable.
- addr_a  out  ADDR_SIZE  RAM port A address.
- din_a  out  DATA_SIZE  RAM port A write data.
- dout_a  in  DATA_SIZE  RAM port A read data.
- en_b, we_b, addr_b, din_b, dout_b: same as the port A signals, for port B.

Behaviour:
- RAM contract: registered read. dout_x is valid on the cycle after en_x=1 with we_x=0. Writes take effect at the edge where en_x && we_x.
- Pattern: P(a) = zero-extend/truncate(a to DATA_SIZE) ^ SEED. Complement pattern is ~P(a).
- Reset: state IDLE. All outputs are 0: en/we/addr/din on both ports, busy, done, pass, err_count and all fail_* outputs.
- FSM states: IDLE, W0, R0, D0, W1, R1, D1, DONE.
  - IDLE/DONE + start → W0. Entering W0 clears err_count, fail_*, done and pass.
  - W0: port A writes P(a), addresses 0..N-1 ascending, one per cycle (en_a=we_a=1). Port B idle. → R0 after address N-1.
  - R0: port B reads addresses 0..N-1 ascending (en_b=1, we_b=0). Port A idle. → D0.
  - D0: one drain cycle, no RAM access, completes the final compare. → W1.
  - W1: port B writes ~P(a), addresses N-1..0 descending. Port A idle. → R1.
  - R1: port A reads addresses N-1..0 descending. Port B idle. → D1.
  - D1: drain cycle. → DONE.
- Address counter: ADDR_SIZE bits, wraps naturally. Phase exit is decided on the terminal count (N-1 ascending, 0 descending), not on wrap.
- Timing: start sampled at edge k; W0 begins at k+1; DONE is entered 4N+3 cycles after k (1027 for N=256). busy=1 in W0..D1 only.
- Compare pipeline:
  - On each read issue, register exp_valid, expected data, address and phase.
  - The next cycle, compare dout of the reading port with the expected data.
  - On mismatch: increment err_count (saturate at all-ones).
  - On the first mismatch only: latch fail_addr, fail_data = actual, fail_phase, and set fail_valid=1.
- Never more than one port is active per cycle, so there is no same-address collision.
- start while busy: ignored, with no effect on timing or results.
- start in DONE: restarts the test, clearing all results.
- rst mid-test: next edge returns to the reset state. RAM enables drop immediately at that edge, and the compare pipeline is flushed (no stale compare after reset).
- Unused ports drive en=0, we=0, addr=0, din=0. din is 0 on any read cycle.

Decomposition:
- Package dpr_bist_pkg:
  - state enum (IDLE..DONE);
  - phase codes PH_R0=0, PH_R1=1;
  - pattern function P(a, SEED).
- Sub-module dpr_bist_checker holds the 1-cycle compare pipeline, the saturating err_count and the first-fail capture. Its inputs are rd_issue, exp_data, addr, phase and rd_data, plus clear.
- The top level holds the FSM, address counter and RAM-port muxing.

Test Plan:
- Fault-free behavioural RAM, defaults, rst then 1-cycle start → done rises exactly 1027 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
- Port trace, same run → W0: we_a=1, addr_a 0x00..0xFF, din_a=addr. R0: en_b only. W1: we_b=1, addr_b 0xFF..0x00, din_b=~addr. R1: en_a only. Never en_a&&en_b in the same cycle.
- RAM model with bit0 stuck-at-1 at addr 0x05, SEED=0 → R0 passes (expects 0x05). R1 reads 0xFB, expects 0xFA. Result: err_count=1, fail_addr=0x05, fail_data=0xFB, fail_phase=1, pass=0.
- SEED=0xA5, stuck-at-0 bit7 at addrs 0x10 and 0x20 → R0 fails at 0x10 first (expects 0xB5, reads 0x35). Result: err_count=2, fail_addr=0x10, fail_phase=0.
- start pulsed again at cycle 300 of a run → ignored; done timing is still 1027 and the results are unchanged.
- rst asserted during W1 → next cycle all RAM enables, busy, done and err_count are 0. A new start then completes normally with pass=1.
